// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// Module   : program_counter
// Purpose  : Instruction-fetch PC register with hold / increment / jump select.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module program_counter #(
  parameter int                ADDR_W     = 14,
  parameter int                STEP       = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jump_en,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] out_addr
);

  localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(STEP);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Jump outranks increment; in_addr is only looked at when a jump is taken.
  always_comb begin
    pc_d = pc_q;
    if (jump_en) begin
      pc_d = in_addr;
    end else if (inc_en) begin
      pc_d = pc_q + c_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out_addr = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// Module   : tb_program_counter
// Purpose  : Self-checking bench for program_counter (vectors + random model).
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_program_counter;

  localparam int ADDR_W = 14;
  localparam int MOD    = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              jump_en;
  logic              inc_en;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] out_addr;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic              jump;
    logic              inc;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] exp;
  } vec_t;

  vec_t vecs [14];

  program_counter #(
    .ADDR_W    (ADDR_W),
    .STEP      (1),
    .RESET_ADDR('0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .jump_en (jump_en),
    .inc_en  (inc_en),
    .in_addr (in_addr),
    .out_addr(out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [ADDR_W-1:0] exp);
    n_cmp++;
    if (out_addr !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, out_addr, exp, $time);
    end
  endtask

  // Drive controls, then let one rising edge pass and settle just after it.
  task automatic tick(input logic j, input logic i, input logic [ADDR_W-1:0] a);
    jump_en = j;
    inc_en  = i;
    in_addr = a;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check the immediate effect, release before the next edge.
  task automatic pulse_reset(input string name);
    #2 reset = 1'b0;
    #1 check(name, '0);
    #1 reset = 1'b1;
  endtask

  initial begin
    int model;
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    jump_en = 1'b1;
    inc_en  = 1'b1;
    in_addr = 14'h2AAA;

    // Reset held: enables active but ignored.
    #1 check("reset_initial", '0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b1, 14'h2AAA);
      check("reset_held", '0);
    end
    #1 reset = 1'b1;
    #1 check("reset_release", '0);
    tick(1'b0, 1'b0, 14'h1555);
    check("post_release_idle", '0);

    // Sequential count, 18 edges.
    for (int k = 1; k <= 18; k++) begin
      tick(1'b0, 1'b1, 14'h0);
      check("count", ADDR_W'(k));
    end

    // Async reset in the middle of a count from 9.
    pulse_reset("rst_to_zero");
    for (int k = 1; k <= 9; k++) tick(1'b0, 1'b1, 14'h0);
    check("count_to_9", 14'd9);
    pulse_reset("async_reset_mid");
    tick(1'b0, 1'b1, 14'h0);
    check("count_after_reset", 14'd1);

    // Table-driven vectors, starting from a fresh reset (PC=0).
    pulse_reset("table_reset");
    vecs[0]  = '{1'b0, 1'b1, 14'h0000, 14'h0001};
    vecs[1]  = '{1'b0, 1'b1, 14'h0000, 14'h0002};
    vecs[2]  = '{1'b1, 1'b0, 14'h0005, 14'h0005};
    vecs[3]  = '{1'b1, 1'b1, 14'h1234, 14'h1234};
    vecs[4]  = '{1'b0, 1'b1, 14'h0FFF, 14'h1235};
    vecs[5]  = '{1'b0, 1'b1, 14'h0FFF, 14'h1236};
    vecs[6]  = '{1'b1, 1'b0, 14'h0007, 14'h0007};
    vecs[7]  = '{1'b0, 1'b0, 14'h3FFF, 14'h0007};
    vecs[8]  = '{1'b0, 1'b0, 14'h2222, 14'h0007};
    vecs[9]  = '{1'b0, 1'b0, 14'h1111, 14'h0007};
    vecs[10] = '{1'b0, 1'b0, 14'h3FFF, 14'h0007};
    vecs[11] = '{1'b1, 1'b0, 14'h3FFF, 14'h3FFF};
    vecs[12] = '{1'b0, 1'b1, 14'h1234, 14'h0000};
    vecs[13] = '{1'b0, 1'b1, 14'h1234, 14'h0001};
    for (int k = 0; k < 14; k++) begin
      tick(vecs[k].jump, vecs[k].inc, vecs[k].addr);
      check($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Randomized run against an arithmetic reference model.
    model = 1;
    for (int k = 0; k < 400; k++) begin
      logic j;
      logic i;
      logic [ADDR_W-1:0] a;
      if ($urandom_range(31) == 0) begin
        pulse_reset("rand_reset");
        model = 0;
      end
      j = ($urandom_range(3) == 0);
      i = ($urandom_range(1) == 1);
      a = ADDR_W'($urandom);
      if (j && $urandom_range(3) == 0) a = 14'h3FFF;
      tick(j, i, a);
      if (j)      model = int'(a);
      else if (i) model = (model + 1) % MOD;
      check("random", ADDR_W'(model));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_counter.md
Name: program_counter

Overview:
- Instruction-fetch program counter for the riscy core.
- Holds the current fetch address and drives it on out_addr.
- Each clock it holds, increments by one word, or loads a jump target, as selected by the fetch/branch control logic.
- Pure sequential register plus next-address mux; sits between the control unit and instruction memory address input.

Parameters:
- ADDR_W, 14, width of in_addr/out_addr and the internal PC register.
- STEP, 1, increment applied when inc_en is asserted (word-addressed memory).
- RESET_ADDR, 0, value loaded into the PC while reset is asserted.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- jump_en  input  1  load in_addr into PC on next rising edge.
- inc_en  input  1  advance PC by STEP on next rising edge.
- in_addr  input  ADDR_W  jump target; may be high-impedance/undriven when jump_en=0.
- out_addr  output  ADDR_W  current PC value, driven directly from the PC register.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset asserted (reset=0):
  - PC immediately becomes RESET_ADDR, independent of clk.
  - out_addr = RESET_ADDR while reset is held.
  - jump_en, inc_en and in_addr are ignored.
- Reset release: the first rising edge with reset=1 evaluates the enables normally. There is no extra synchronization cycle.
- Rising edge of clk with reset deasserted, priority order:
  1. jump_en=1: PC <= in_addr, regardless of inc_en.
  2. else inc_en=1: PC <= (PC + STEP) mod 2^ADDR_W.
  3. else: PC holds.
- Latency:
  - out_addr reflects the new PC in the same cycle after the edge (register output, no combinational path from inputs).
  - A jump target is visible one cycle after jump_en is sampled high.
- Wrap-around: with ADDR_W=14, STEP=1, PC=16383 plus increment gives 0. No overflow flag; the carry is discarded.
- in_addr is never sampled unless jump_en=1 at the edge. Z/X on in_addr must not propagate to PC while jump_en=0.
- Enables that are X/undefined while reset is asserted have no effect. The PC stays at RESET_ADDR.
- Reset asserted mid-operation (e.g. between edges during an increment sequence) forces RESET_ADDR immediately. The next count after release starts from RESET_ADDR.
- out_addr is never tri-stated. The register is always driven.
- No other state; single ADDR_W-bit register.

Test Plan:
- Reset: hold reset=0 with in_addr=Z and enables undefined for 2 edges -> out_addr=0 throughout; release reset -> still 0 until first enabled edge.
- Sequential count: reset released, inc_en=1, jump_en=0, in_addr=Z for 18 clock edges -> out_addr steps 1,2,...,18, one increment per rising edge, no X.
- Jump priority: PC=5, jump_en=1, inc_en=1, in_addr=0x1234 -> next out_addr=0x1234 (not 6); then jump_en=0 -> 0x1235, 0x1236.
- Hold: PC=7, inc_en=0, jump_en=0 for 4 edges -> out_addr stays 7.
- Wrap: jump to 0x3FFF, then inc_en=1 -> out_addr=0x0000, then 0x0001.
- Async reset mid-count: counting at PC=9, drive reset=0 between clock edges -> out_addr=0 before the next rising edge; release with inc_en=1 -> 1 on the following edge.
